// File: rtl/static_consumption_bd.sv
// Static-power characterisation model for an AND2_X4 cell: synchronises the
// cell inputs and the measurement request, waits for the inputs to settle,
// averages the per-state leakage over a fixed window and reports it in nW.
module static_consumption_bd #(
    parameter logic [31:0] LEAK_00       = 32'd48000,
    parameter logic [31:0] LEAK_01       = 32'd61000,
    parameter logic [31:0] LEAK_10       = 32'd55000,
    parameter logic [31:0] LEAK_11       = 32'd101000,
    parameter int unsigned WIN_LOG2      = 4,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter real         LSB_NW        = 0.001,
    parameter real         CAPA_FF       = 0.0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din2,
    input  logic start_measure,
    input  logic fin_test,
    output real  measure_int,
    output real  capa_charge_val
);

    localparam int unsigned ACC_W = 32 + WIN_LOG2;
    localparam int unsigned SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_FIN     = 2'd3
    } state_t;

    // Synchroniser and edge-detect history
    logic r_din_s1, r_din_s2, r_din_d;
    logic r_din2_s1, r_din2_s2, r_din2_d;
    logic r_start_s1, r_start_s2, r_start_d;

    // Control and datapath registers
    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [SET_W-1:0]    r_settle_cnt;
    logic                r_pending;
    logic [31:0]         r_avg;

    // Next-state values
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [WIN_LOG2-1:0] w_win_nxt;
    logic [SET_W-1:0]    w_settle_nxt;
    logic                w_pending_nxt;
    logic [31:0]         w_avg_nxt;

    logic        w_req;
    logic        w_in_chg;
    logic [31:0] w_sample;

    // Two-flop synchronisers plus one-cycle history for change/toggle detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
            r_din_d    <= 1'b0;
            r_din2_s1  <= 1'b0;
            r_din2_s2  <= 1'b0;
            r_din2_d   <= 1'b0;
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
        end else begin
            r_din_s1   <= din;
            r_din_s2   <= r_din_s1;
            r_din_d    <= r_din_s2;
            r_din2_s1  <= din2;
            r_din2_s2  <= r_din2_s1;
            r_din2_d   <= r_din2_s2;
            r_start_s1 <= start_measure;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
        end
    end

    assign w_req    = r_start_s2 ^ r_start_d;
    assign w_in_chg = (r_din_s2 ^ r_din_d) | (r_din2_s2 ^ r_din2_d);

    // Leakage sample for the current synchronised input state
    always_comb begin
        w_sample = LEAK_00;
        case ({r_din_s2, r_din2_s2})
            2'b00:   w_sample = LEAK_00;
            2'b01:   w_sample = LEAK_01;
            2'b10:   w_sample = LEAK_10;
            default: w_sample = LEAK_11;
        endcase
    end

    assign w_acc_sum = r_acc + ACC_W'(w_sample);

    // Next-state and datapath control; fin_test beats input change beats request
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_win_nxt     = r_win_cnt;
        w_settle_nxt  = r_settle_cnt;
        w_pending_nxt = r_pending;
        w_avg_nxt     = r_avg;

        if (fin_test) begin
            w_state_nxt   = S_FIN;
            w_pending_nxt = 1'b0;
            w_acc_nxt     = '0;
            w_win_nxt     = '0;
        end else if (r_state == S_FIN) begin
            w_state_nxt = S_IDLE;
        end else if (w_in_chg) begin
            // An aborted window leaves its request outstanding
            w_state_nxt   = S_SETTLE;
            w_settle_nxt  = SET_W'(SETTLE_CYCLES);
            w_acc_nxt     = '0;
            w_win_nxt     = '0;
            w_pending_nxt = r_pending | w_req | (r_state == S_MEASURE);
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Starting a window consumes the request; a new toggle queues one more
                    w_pending_nxt = w_req;
                    if (r_pending) begin
                        w_state_nxt = S_MEASURE;
                        w_acc_nxt   = '0;
                        w_win_nxt   = '0;
                    end
                end
                S_SETTLE: begin
                    w_pending_nxt = r_pending | w_req;
                    if (r_settle_cnt <= SET_W'(1)) begin
                        w_state_nxt  = S_IDLE;
                        w_settle_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle_cnt - SET_W'(1);
                    end
                end
                S_MEASURE: begin
                    w_pending_nxt = r_pending | w_req;
                    if (r_win_cnt == WIN_LAST) begin
                        w_avg_nxt   = 32'(w_acc_sum >> WIN_LOG2);
                        w_state_nxt = S_IDLE;
                        w_acc_nxt   = '0;
                        w_win_nxt   = '0;
                    end else begin
                        w_acc_nxt = w_acc_sum;
                        w_win_nxt = r_win_cnt + WIN_LOG2'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_win_cnt    <= '0;
            r_settle_cnt <= '0;
            r_pending    <= 1'b0;
            r_avg        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_win_cnt    <= w_win_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_pending    <= w_pending_nxt;
            r_avg        <= w_avg_nxt;
        end
    end

    // Result scaled from the registered pW average; capacitance is a constant
    assign measure_int     = real'(r_avg) * LSB_NW;
    assign capa_charge_val = CAPA_FF;

endmodule

// File: tb/tb_static_consumption_bd.sv
// Self-checking bench for static_consumption_bd: directed scenarios followed by
// randomised input-state measurements, checked against a leakage-table model.
module tb_static_consumption_bd;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din2;
    logic start_measure;
    logic fin_test;
    real  measure_int;
    real  capa_charge_val;

    int   n_vec = 0;
    int   n_err = 0;
    real  model_meas;
    real  val;
    int   cyc;
    int   pick;
    bit   pa, pb;
    bit   prev_a, prev_b;

    static_consumption_bd dut (
        .clk             (clk),
        .rst             (rst),
        .din             (din),
        .din2            (din2),
        .start_measure   (start_measure),
        .fin_test        (fin_test),
        .measure_int     (measure_int),
        .capa_charge_val (capa_charge_val)
    );

    always #5 clk = ~clk;

    // Leakage table in pW, indexed by {din, din2}
    function automatic real leak_nw(input bit a, input bit b);
        int unsigned tbl [4];
        tbl[0] = 48000;
        tbl[1] = 61000;
        tbl[2] = 55000;
        tbl[3] = 101000;
        return real'(tbl[{a, b}]) / 1000.0;
    endfunction

    function automatic bit close(input real a, input real b);
        return ((a - b) < 1.0e-6) && ((b - a) < 1.0e-6);
    endfunction

    task automatic chk(input string tag, input real obs, input real exp);
        n_vec++;
        assert (close(obs, exp) === 1'b1)
        else begin
            n_err++;
            $error("FAIL %s observed=%0.6f expected=%0.6f", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Poll until measure_int leaves 'old', bounded by maxc cycles
    task automatic wait_update(input real old, input int maxc, output real v, output int c);
        c = 0;
        while (close(measure_int, old) && (c < maxc)) begin
            tick(1);
            c++;
        end
        v = measure_int;
    endtask

    // Settle a new input state, request once, and check the exact update cycle
    task automatic measure_exact(input string tag, input bit a, input bit b, input int gap);
        din  = a;
        din2 = b;
        tick(gap);
        start_measure = ~start_measure;
        tick(19);
        chk({tag, "_before"}, measure_int, model_meas);
        tick(1);
        model_meas = leak_nw(a, b);
        chk({tag, "_after"}, measure_int, model_meas);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        din           = 1'b0;
        din2          = 1'b0;
        start_measure = 1'b0;
        fin_test      = 1'b0;
        model_meas    = 0.0;
        tick(3);
        chk("reset_meas", measure_int, 0.0);
        chk("reset_capa", capa_charge_val, 0.0);
        rst = 1'b0;
        tick(10);
        chk("idle_meas", measure_int, 0.0);

        // First measurement with exact 20-cycle latency, then the state sweep
        measure_exact("m00", 1'b0, 1'b0, 10);
        chk("capa_run", capa_charge_val, 0.0);
        measure_exact("m01", 1'b0, 1'b1, 10);
        measure_exact("m10", 1'b1, 1'b0, 10);
        measure_exact("m11", 1'b1, 1'b1, 10);

        // Input change at window cycle 8 aborts; new-state result follows later
        start_measure = ~start_measure;
        tick(12);
        din = 1'b0;
        tick(8);
        chk("abort_no_update", measure_int, model_meas);
        wait_update(model_meas, 60, val, cyc);
        chk("abort_timeout", real'(cyc < 60), 1.0);
        model_meas = leak_nw(1'b0, 1'b1);
        chk("abort_result", val, model_meas);

        // Three toggles within one window collapse into one extra measurement
        din  = 1'b1;
        din2 = 1'b0;
        tick(10);
        start_measure = ~start_measure;
        tick(8);
        start_measure = ~start_measure;
        tick(4);
        start_measure = ~start_measure;
        tick(8);
        model_meas = leak_nw(1'b1, 1'b0);
        chk("multi_first", measure_int, model_meas);
        din  = 1'b1;
        din2 = 1'b1;
        wait_update(model_meas, 60, val, cyc);
        chk("multi_timeout", real'(cyc < 60), 1.0);
        model_meas = leak_nw(1'b1, 1'b1);
        chk("multi_second", val, model_meas);
        din  = 1'b0;
        din2 = 1'b0;
        tick(60);
        chk("multi_no_third", measure_int, model_meas);

        // fin_test mid-window freezes the result; afterwards a request works normally
        start_measure = ~start_measure;
        tick(10);
        fin_test = 1'b1;
        tick(15);
        chk("fin_hold", measure_int, model_meas);
        fin_test = 1'b0;
        tick(40);
        chk("fin_no_update", measure_int, model_meas);
        measure_exact("fin_after", 1'b0, 1'b0, 5);

        // Randomised input states, each different from the previous one
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do begin
                pick = int'($urandom_range(0, 3));
                pa   = pick[1];
                pb   = pick[0];
            end while ((pa == prev_a) && (pb == prev_b));
            measure_exact($sformatf("rnd%0d", i), pa, pb, 8 + int'($urandom_range(0, 6)));
            prev_a = pa;
            prev_b = pb;
        end

        // Reset mid-window clears the result and discards the pending request
        if (start_measure == 1'b0) begin
            start_measure = 1'b1;
            tick(25);
        end
        start_measure = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        model_meas = 0.0;
        chk("rst_mid_meas", measure_int, model_meas);
        chk("rst_mid_capa", capa_charge_val, 0.0);
        rst = 1'b0;
        tick(50);
        chk("rst_discard", measure_int, model_meas);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/static_consumption_bd.md
Name: static_consumption_bd

Overview:
Behavioural/RTL model of the static-power (leakage) characterisation bench for a 2-input AND cell (AND2_X4). It holds a per-input-state leakage table and drives the cell inputs din/din2. On each measurement request it averages the leakage over a fixed window and reports the result in nW as a real value. The characterisation testbench uses the result to write Liberty leakage_power "when" entries.

Parameters:
LEAK_00, 48000, leakage in pW for din=0, din2=0 (32-bit unsigned)
LEAK_01, 61000, leakage in pW for din=0, din2=1
LEAK_10, 55000, leakage in pW for din=1, din2=0
LEAK_11, 101000, leakage in pW for din=1, din2=1
WIN_LOG2, 4, log2 of averaging window length in clock cycles (window = 16)
SETTLE_CYCLES, 3, cycles the inputs must be stable before sampling may start
LSB_NW, 0.001, real scale from integer pW to measure_int nW
CAPA_FF, 0.0, real load-capacitance value reported on capa_charge_val (fF)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
din  input  1  cell input A1, asynchronous to clk
din2  input  1  cell input A2, asynchronous to clk
start_measure  input  1  measurement request; every toggle (either edge) is one request
fin_test  input  1  end-of-test; 1 aborts activity and freezes the block
measure_int  output  real  last averaged leakage in nW
capa_charge_val  output  real  constant load capacitance, equal to CAPA_FF

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE, accumulator 0, cycle counter 0, pending request 0, measure_int = 0.0. Synchronizer flops clear to 0.
- capa_charge_val = CAPA_FF at all times, including during reset.
- din, din2 and start_measure each pass through a 2-flop synchronizer. A request is detected when the synced start_measure differs from its previous registered value (1-cycle edge detect).
- Leakage sample per cycle = LEAK_{din_s,din2_s}, using the synced inputs.
- FSM states:
  - IDLE: a request sets pending=1. pending=1 with settle complete -> MEASURE.
  - SETTLE: entered on any synced din/din2 change from any state except FIN. The counter is loaded with SETTLE_CYCLES. Exits to IDLE after SETTLE_CYCLES stable cycles; a further change reloads the counter.
  - MEASURE: adds the sample each cycle into an accumulator of 32+WIN_LOG2 bits (no overflow possible). After 2^WIN_LOG2 samples: measure_int <= (acc >> WIN_LOG2) * LSB_NW, pending cleared, -> IDLE.
  - FIN: entered whenever fin_test=1. Aborts any window, clears pending, holds measure_int. Returns to IDLE when fin_test=0.
- Latency: if inputs are settled, measure_int updates exactly 2^WIN_LOG2 + 4 clk cycles after the start_measure toggle (2 sync, 1 detect, 1 enter MEASURE, window, update edge).
- An input change during MEASURE aborts the window: the accumulator clears, pending stays 1, the FSM goes to SETTLE, and the window restarts after settle.
- Requests during MEASURE or SETTLE set pending (1 bit). Multiple requests collapse into one extra measurement.
- Simultaneous input change and request in one cycle: SETTLE wins, and the request is kept pending.
- measure_int changes only at the end of a complete window or on reset. Between updates it holds its previous value.
- Priority: rst > fin_test > input change > request.
- Integration: with clk at 10 ns and the defaults, a measurement completes in 200 ns. The testbench must use a request-to-read delay of at least that, or the read returns the previous value.

Test Plan:
- Reset, then din=0, din2=0, settle, toggle start_measure -> measure_int = 48.000 nW exactly 20 cycles after the toggle; capa_charge_val = CAPA_FF throughout.
- Sweep (0,1), (1,0), (1,1), each settled, with one toggle each -> measure_int = 61.0, 55.0, 101.0 nW in sequence.
- Toggle start_measure, then flip din at cycle 8 of the window -> window aborts, measure_int unchanged until a full new window completes with the new-state value.
- Three toggles during one MEASURE window -> exactly two updates total, with no third window.
- fin_test=1 mid-window -> measure_int held and no update; after fin_test=0 a new toggle gives a normal update.
- rst asserted mid-window -> measure_int = 0.0 next cycle and state IDLE; the pending request is discarded.
